dshot_pwm_output: RTL and testbench
===================================

Name: dshot_pwm_output

Overview:
Downstream stage of the DShot input decoder. Consumes decoded frames (speed, special command, CRC status) and produces a glitch-free servo-style PWM output for a legacy ESC.
- Includes arming, a frame-loss failsafe and a bad-CRC counter.
- Sits between the decoder and the board output pin.

Parameters:
CLK_HZ, 16_000_000, system clock frequency; must be an integer multiple of 1 MHz
PERIOD_US, 20000, PWM frame period in microseconds
MIN_US, 1000, pulse width for zero throttle, stop, disarmed and failsafe
ARM_FRAMES, 10, consecutive valid motor-stop frames required to arm (1..255)
TIMEOUT_MS, 100, frame-loss time before failsafe or disarm

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_stb  in  1  one-cycle pulse when the decoder has updated its frame outputs
set_speed  in  11  decoded throttle, 0..1999 (raw value minus 48)
special_command  in  6  decoded command value
is_special  in  1  frame is a command (raw value < 48)
crc_valid  in  1  frame CRC is correct
pwm_out  out  1  PWM output
armed  out  1  state == ARMED
failsafe  out  1  high from timeout in ARMED until re-armed
pulse_us  out  12  pulse width applied in the current period
bad_crc_cnt  out  8  saturating count of frame_stb with crc_valid=0

Behaviour:
Reset: all outputs 0 except pulse_us=MIN_US. State DISARMED; tick, period, timeout and arm counters cleared. Reset mid-period drops pwm_out immediately.
Timebase: us_tick every CLK_HZ/1e6 clk cycles; ms_tick every 1000 us_ticks.
Frame qualification (frame_stb=1 only):
- crc_valid=0: bad_crc_cnt += 1, saturating at 255. No other effect; no timeout refresh.
- crc_valid=1: timeout counter cleared. Classified as STOP (is_special, special_command==0), OTHER_CMD (is_special, nonzero), or THROTTLE (!is_special).
Throttle mapping: target_us = MIN_US + (min(set_speed,1999) >> 1), range 1000..1999 with defaults. STOP gives target_us = MIN_US.
States:
- DISARMED: target forced to MIN_US. STOP → ARMING with arm_cnt=1.
- ARMING: STOP increments arm_cnt; when arm_cnt reaches ARM_FRAMES → ARMED, and armed rises 1 cycle after that frame_stb. THROTTLE → DISARMED. OTHER_CMD is ignored. Timeout → DISARMED.
- ARMED: THROTTLE and STOP update target_us; OTHER_CMD only refreshes the timeout. Timeout → FAILSAFE.
- FAILSAFE: target forced to MIN_US, failsafe=1. STOP → ARMING (arm_cnt=1). failsafe clears on entering ARMED.
- ARM_FRAMES=1: the first STOP frame goes directly to ARMED.
Timeout: ms counter increments on ms_tick and saturates. Expiry is when the count reaches TIMEOUT_MS. If a valid frame arrives in the same cycle as expiry, the frame wins: no transition.
PWM:
- period_cnt counts us_ticks 0..PERIOD_US-1 and wraps.
- pulse_us loads target_us only on the wrap cycle.
- If the wrap and a target update coincide, the old target loads; the new value applies next period. Worst-case latency is 1 period + 1 cycle.
- pwm_out is registered: high while period_cnt < pulse_us.
- No mid-period width change, so no runt or stretched pulses.

Optional Feature:
Macro DSHOT_PWM_3D_EN.
- Defined: bidirectional mapping with center C = MIN_US+500.
  - STOP, disarmed and failsafe drive C.
  - set_speed 0..999: target = C - (set_speed>>1), range 1500..1001.
  - set_speed 1000..1999: target = C + ((set_speed-1000)>>1), range 1500..1999.
  - pulse_us reset value is C.
- Undefined: unidirectional mapping as above.

Decomposition:
Package dshot_pkg holds:
- state enum {DISARMED, ARMING, ARMED, FAILSAFE}
- DSHOT_CMD_MOTOR_STOP=0
- DSHOT_THROTTLE_MAX=1999
- DSHOT_CMD_OFFSET=48

Sub-module dshot_us_tick_gen (CLK_HZ) emits us_tick and ms_tick; reset by rst_n.

Test Plan:
1. Reset and idle: hold rst_n low 5 cycles mid-high-pulse → pwm_out 0 at once. After release → 1000 us high (16000 clk) every 20000 us, armed=0.
2. Arm and throttle: 10 STOP frames 1 ms apart → armed=1 one cycle after the 10th stb. Then THROTTLE 1000 → next period high 1500 us. THROTTLE 1999 → 1999 us. THROTTLE 0 → 1000 us.
3. Bad CRC: 300 frames crc_valid=0, speed 1500, while ARMED → pulse unchanged, bad_crc_cnt=255. Frames at 1 ms spacing do not refresh timeout, so failsafe at 100 ms.
4. Failsafe and recovery: ARMED at 1500 us, stop frames for 100 ms → failsafe=1, armed=0, pulse 1000 from next period. Then 10 STOP frames → armed=1, failsafe=0.
5. Arming abort: 5 STOP then THROTTLE 500 → DISARMED, armed stays 0, pulse 1000. Frame_stb coinciding with the period wrap → new width starts one period later.
6. With DSHOT_PWM_3D_EN: armed, THROTTLE 0 → 1500 us; 999 → 1001 us; 1000 → 1500 us; 1999 → 1999 us. Failsafe → 1500 us.

Source files
------------

// File: rtl/dshot_pkg.sv
// Shared types, constants and throttle mapping for the DShot PWM output stage.
// DSHOT_PWM_3D_EN selects the bidirectional (centre-referenced) throttle mapping.
package dshot_pkg;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      FAILSAFE = 2'd3
   } dshotState_t;

   localparam logic [5:0] DSHOT_CMD_MOTOR_STOP = 6'd0;
   localparam int         DSHOT_THROTTLE_MAX   = 1999;
   localparam int         DSHOT_CMD_OFFSET     = 48;

   // Pulse width for stop, disarmed and failsafe.
   function automatic logic [11:0] restUs(input logic [11:0] minUs);
`ifdef DSHOT_PWM_3D_EN
      return minUs + 12'd500;
`else
      return minUs;
`endif
   endfunction

   function automatic logic [11:0] throttleToUs(input logic [10:0] speed, input logic [11:0] minUs);
      logic [10:0] s;
      s = (speed > 11'(DSHOT_THROTTLE_MAX)) ? 11'(DSHOT_THROTTLE_MAX) : speed;
`ifdef DSHOT_PWM_3D_EN
      if (s < 11'd1000) begin
         return minUs + 12'd500 - 12'(s >> 1);
      end
      return minUs + 12'd500 + 12'((s - 11'd1000) >> 1);
`else
      return minUs + 12'(s >> 1);
`endif
   endfunction

endpackage

// File: rtl/dshot_us_tick_gen.sv
// Microsecond and millisecond strobes derived from the system clock.
// Both strobes are single-cycle pulses; msTick coincides with every 1000th usTick.
module dshot_us_tick_gen #(
   parameter int CLK_HZ = 16_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic usTick,
   output logic msTick
);

   localparam int DIV = CLK_HZ / 1_000_000;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0] divCnt;
   logic [9:0]    usCnt;

   assign usTick = (divCnt == '0);
   assign msTick = usTick & (usCnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt <= DIV_LAST;
         usCnt  <= 10'd999;
      end else begin
         if (usTick) begin
            divCnt <= DIV_LAST;
         end else begin
            divCnt <= divCnt - 1'b1;
         end
         if (usTick) begin
            usCnt <= (usCnt == '0) ? 10'd999 : usCnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/dshot_pwm_output.sv
// Servo-style PWM stage fed by the DShot decoder: arming, frame-loss failsafe, bad-CRC count.
// Define DSHOT_PWM_3D_EN for the bidirectional (centre-referenced) throttle mapping.
//
// state     | meaning
// DISARMED  | output held at rest width, waiting for a STOP frame
// ARMING    | counting consecutive STOP frames
// ARMED     | throttle/STOP frames set the pulse width
// FAILSAFE  | frames lost while armed; rest width until re-armed
module dshot_pwm_output #(
   parameter int CLK_HZ     = 16_000_000,
   parameter int PERIOD_US  = 20000,
   parameter int MIN_US     = 1000,
   parameter int ARM_FRAMES = 10,
   parameter int TIMEOUT_MS = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_stb,
   input  logic [10:0] set_speed,
   input  logic [5:0]  special_command,
   input  logic        is_special,
   input  logic        crc_valid,
   output logic        pwm_out,
   output logic        armed,
   output logic        failsafe,
   output logic [11:0] pulse_us,
   output logic [7:0]  bad_crc_cnt
);
   import dshot_pkg::*;

   localparam logic [11:0]    MIN_W       = 12'(MIN_US);
   localparam logic [11:0]    REST_US     = restUs(MIN_W);
   localparam int             TW          = $clog2(TIMEOUT_MS + 1);
   localparam logic [TW-1:0]  TIMEOUT_CNT = TW'(TIMEOUT_MS);
   localparam logic [15:0]    PERIOD_LAST = 16'(PERIOD_US - 1);
   localparam logic [7:0]     ARM_LAST    = 8'(ARM_FRAMES);

   logic usTick;
   logic msTick;

   dshot_us_tick_gen #(.CLK_HZ(CLK_HZ)) uTickGen (
      .clk    (clk),
      .rst_n  (rst_n),
      .usTick (usTick),
      .msTick (msTick)
   );

   dshotState_t   state;
   logic [7:0]    armCnt;
   logic [11:0]   targetUs;
   logic [TW-1:0] lossMs;
   logic [15:0]   periodCnt;
   logic          validFrame;
   logic          isStop;
   logic          isThrottle;
   logic          timedOut;
   logic          periodWrap;

   assign validFrame = frame_stb & crc_valid;
   assign isStop     = validFrame & is_special & (special_command == DSHOT_CMD_MOTOR_STOP);
   assign isThrottle = validFrame & ~is_special;
   // A valid frame in the expiry cycle wins over the timeout.
   assign timedOut   = (lossMs == TIMEOUT_CNT) & ~validFrame;
   assign periodWrap = usTick & (periodCnt == PERIOD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lossMs      <= '0;
         bad_crc_cnt <= '0;
         periodCnt   <= '0;
         pulse_us    <= REST_US;
         pwm_out     <= 1'b0;
      end else begin
         if (validFrame) begin
            lossMs <= '0;
         end else if (msTick && lossMs != TIMEOUT_CNT) begin
            lossMs <= lossMs + 1'b1;
         end
         if (frame_stb && !crc_valid && bad_crc_cnt != 8'hFF) begin
            bad_crc_cnt <= bad_crc_cnt + 8'd1;
         end
         if (usTick) begin
            periodCnt <= (periodCnt == PERIOD_LAST) ? 16'd0 : periodCnt + 16'd1;
         end
         // Width only changes at the period boundary, so no runt or stretched pulses.
         if (periodWrap) begin
            pulse_us <= targetUs;
         end
         pwm_out <= (periodCnt < {4'd0, pulse_us});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= DISARMED;
         armCnt   <= '0;
         targetUs <= REST_US;
         armed    <= 1'b0;
         failsafe <= 1'b0;
      end else begin
         case (state)
            DISARMED, FAILSAFE: begin
               if (isStop) begin
                  armCnt <= 8'd1;
                  if (8'd1 >= ARM_LAST) begin
                     state    <= ARMED;
                     armed    <= 1'b1;
                     failsafe <= 1'b0;
                  end else begin
                     state <= ARMING;
                  end
               end
            end
            ARMING: begin
               if (isStop) begin
                  armCnt <= armCnt + 8'd1;
                  if (armCnt + 8'd1 >= ARM_LAST) begin
                     state    <= ARMED;
                     armed    <= 1'b1;
                     failsafe <= 1'b0;
                     targetUs <= REST_US;
                  end
               end else if (isThrottle || timedOut) begin
                  state <= DISARMED;
               end
            end
            ARMED: begin
               if (isThrottle) begin
                  targetUs <= throttleToUs(set_speed, MIN_W);
               end else if (isStop) begin
                  targetUs <= REST_US;
               end else if (timedOut) begin
                  state    <= FAILSAFE;
                  armed    <= 1'b0;
                  failsafe <= 1'b1;
                  targetUs <= REST_US;
               end
            end
            default: begin
               state    <= DISARMED;
               armed    <= 1'b0;
               targetUs <= REST_US;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dshot_pwm_output.sv
// Self-checking bench for dshot_pwm_output: cycle-level reference model plus directed literal checks.
// Build with DSHOT_PWM_3D_EN defined to exercise the bidirectional mapping.
module tb_dshot_pwm_output;

   localparam int CLK_HZ     = 2_000_000;
   localparam int PERIOD_US  = 2100;
   localparam int MIN_US     = 1000;
   localparam int ARM_FRAMES = 4;
   localparam int TIMEOUT_MS = 6;
   localparam int DIV        = CLK_HZ / 1_000_000;
   localparam int PER_CYC    = DIV * PERIOD_US;
   localparam int MS_CYC     = DIV * 1000;
`ifdef DSHOT_PWM_3D_EN
   localparam int REST_US = MIN_US + 500;
   localparam int NTHR    = 4;
   int thrSpd [NTHR] = '{0, 999, 1000, 1999};
   int thrUs  [NTHR] = '{1500, 1001, 1500, 1999};
`else
   localparam int REST_US = MIN_US;
   localparam int NTHR    = 3;
   int thrSpd [NTHR] = '{1000, 1999, 0};
   int thrUs  [NTHR] = '{1500, 1999, 1000};
`endif
   localparam int M_DIS = 0, M_ARMING = 1, M_ARMED = 2, M_FS = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_stb = 1'b0;
   logic [10:0] set_speed = '0;
   logic [5:0]  special_command = '0;
   logic        is_special = 1'b0;
   logic        crc_valid = 1'b0;
   logic        pwm_out;
   logic        armed;
   logic        failsafe;
   logic [11:0] pulse_us;
   logic [7:0]  bad_crc_cnt;

   int checks = 0;
   int errors = 0;

   dshot_pwm_output #(
      .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
      .ARM_FRAMES(ARM_FRAMES), .TIMEOUT_MS(TIMEOUT_MS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_stb(frame_stb), .set_speed(set_speed),
      .special_command(special_command), .is_special(is_special), .crc_valid(crc_valid),
      .pwm_out(pwm_out), .armed(armed), .failsafe(failsafe), .pulse_us(pulse_us),
      .bad_crc_cnt(bad_crc_cnt)
   );

   always #5 clk = ~clk;

   function automatic int expectUs(int spd);
      int s;
      s = (spd > 1999) ? 1999 : spd;
`ifdef DSHOT_PWM_3D_EN
      if (s < 1000) return REST_US - s / 2;
      return REST_US + (s - 1000) / 2;
`else
      return MIN_US + s / 2;
`endif
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: the timebase is pure arithmetic on the cycle index since reset release.
   longint mCyc = 0;
   longint mLastClr = -1;
   int     mState = M_DIS;
   int     mArmCnt = 0;
   int     mTarget = REST_US;
   int     mPulse = REST_US;
   int     mBad = 0;
   bit     mPwm = 0, mArmed = 0, mFs = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mCyc = 0; mLastClr = -1; mState = M_DIS; mArmCnt = 0;
         mTarget = REST_US; mPulse = REST_US; mBad = 0;
         mPwm = 0; mArmed = 0; mFs = 0;
      end else begin
         longint k;
         bit valid, isStop, isThr, expired;
         k       = mCyc;
         valid   = frame_stb && crc_valid;
         isStop  = valid && is_special && (special_command == 0);
         isThr   = valid && !is_special;
         expired = (k / MS_CYC - (mLastClr + 1) / MS_CYC) >= TIMEOUT_MS;
         mPwm = ((k / DIV) % PERIOD_US) < mPulse;
         if (k % PER_CYC == PER_CYC - 1) mPulse = mTarget;
         if (frame_stb && !crc_valid && mBad < 255) mBad++;
         if (valid) mLastClr = k;
         case (mState)
            M_DIS, M_FS: if (isStop) begin
               mArmCnt = 1;
               if (mArmCnt >= ARM_FRAMES) begin mState = M_ARMED; mFs = 0; mTarget = REST_US; end
               else mState = M_ARMING;
            end
            M_ARMING: begin
               if (isStop) begin
                  mArmCnt++;
                  if (mArmCnt >= ARM_FRAMES) begin mState = M_ARMED; mFs = 0; mTarget = REST_US; end
               end else if (isThr || (!valid && expired)) mState = M_DIS;
            end
            default: begin
               if (isThr) mTarget = expectUs(int'(set_speed));
               else if (isStop) mTarget = REST_US;
               else if (!valid && expired) begin mState = M_FS; mFs = 1; mTarget = REST_US; end
            end
         endcase
         mArmed = (mState == M_ARMED);
         mCyc++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && errors < 200) begin
         checks++;
         if (pwm_out !== mPwm || armed !== mArmed || failsafe !== mFs ||
             pulse_us !== 12'(mPulse) || bad_crc_cnt !== 8'(mBad)) begin
            errors++;
            $display("FAIL model_cmp cycle %0d: pwm/armed/fs/pulse/bad got %b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                     mCyc, pwm_out, armed, failsafe, pulse_us, bad_crc_cnt,
                     mPwm, mArmed, mFs, mPulse, mBad);
         end
      end
   end

   logic       kaSp = 1'b0;
   logic [5:0] kaCmd = '0;
   logic [10:0] kaSpd = '0;

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic sendFrame(input logic sp, input logic [5:0] cmd, input logic [10:0] spd, input logic crc);
      is_special = sp; special_command = cmd; set_speed = spd; crc_valid = crc;
      frame_stb = 1'b1;
      if (crc) begin kaSp = sp; kaCmd = cmd; kaSpd = spd; end
      tick(1);
      frame_stb = 1'b0;
   endtask

   // Idle while repeating the last valid frame every 1000 cycles to hold off the timeout.
   task automatic idleKa(input int n);
      for (int i = 0; i < n; i++) begin
         if (i % 1000 == 999) sendFrame(kaSp, kaCmd, kaSpd, 1'b1);
         else tick(1);
      end
   endtask

   task automatic measure(output int hi, output int lo);
      int n;
      n = 0; while (pwm_out && n < PER_CYC) begin tick(1); n++; end
      n = 0; while (!pwm_out && n < PER_CYC) begin tick(1); n++; end
      hi = 0; while (pwm_out && hi < PER_CYC) begin tick(1); hi++; end
      lo = 0; while (!pwm_out && lo < PER_CYC) begin tick(1); lo++; end
   endtask

   task automatic armSeq(input string name);
      for (int i = 0; i < ARM_FRAMES - 1; i++) begin
         sendFrame(1'b1, 6'd0, 11'd0, 1'b1);
         tick(499);
      end
      is_special = 1'b1; special_command = 6'd0; crc_valid = 1'b1; frame_stb = 1'b1;
      kaSp = 1'b1; kaCmd = 6'd0;
      chk({name, "_armed_during_stb"}, armed, 0);
      tick(1);
      frame_stb = 1'b0;
      chk({name, "_armed_next_cycle"}, armed, 1);
      chk({name, "_failsafe_clear"}, failsafe, 0);
   endtask

   initial begin
      #(10 * 150_000);
      errors++;
      $display("FAIL watchdog: run did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hi, lo, n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick(600);
      chk("pre_reset_high", pwm_out, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_pwm_drop", pwm_out, 0);
      chk("reset_pulse", pulse_us, REST_US);
      chk("reset_armed", armed, 0);
      chk("reset_bad_crc", bad_crc_cnt, 0);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b1;
      measure(hi, lo);
      chk("idle_width", hi, REST_US * DIV);
      chk("idle_period", hi + lo, PER_CYC);
      chk("idle_armed", armed, 0);

      armSeq("arm1");
      for (int i = 0; i < NTHR; i++) begin
         sendFrame(1'b0, 6'd0, 11'(thrSpd[i]), 1'b1);
         idleKa(PER_CYC + 10);
         chk("throttle_pulse", pulse_us, thrUs[i]);
         if (i == 0) begin
            measure(hi, lo);
            chk("throttle_width", hi, thrUs[0] * DIV);
            chk("throttle_period", hi + lo, PER_CYC);
         end
      end

      sendFrame(1'b0, 6'd0, 11'd1000, 1'b1);
      idleKa(PER_CYC + 10);
      chk("badcrc_pre_pulse", pulse_us, 1500);
      for (int i = 0; i < 300; i++) begin
         sendFrame(1'b0, 6'd0, 11'd1500, 1'b0);
         tick(39);
         if (i == 150) chk("badcrc_pulse_hold", pulse_us, 1500);
      end
      chk("badcrc_saturate", bad_crc_cnt, 255);
      n = 0; while (!failsafe && n < 4000) begin tick(1); n++; end
      chk("badcrc_failsafe", failsafe, 1);
      chk("badcrc_disarmed", armed, 0);
      tick(PER_CYC + 10);
      chk("failsafe_pulse", pulse_us, REST_US);

      armSeq("recover");
      n = 0; while (!failsafe && n < 15000) begin tick(1); n++; end
      chk("silence_failsafe", failsafe, 1);
      chk("silence_armed", armed, 0);

      sendFrame(1'b1, 6'd0, 11'd0, 1'b1); tick(499);
      sendFrame(1'b1, 6'd0, 11'd0, 1'b1); tick(499);
      sendFrame(1'b0, 6'd0, 11'd500, 1'b1);
      tick(5);
      chk("abort_armed", armed, 0);
      tick(PER_CYC + 10);
      chk("abort_pulse", pulse_us, REST_US);

      armSeq("arm2");
      n = 0;
      while (mCyc % PER_CYC != PER_CYC - 1 && n < PER_CYC + 2) begin tick(1); n++; end
      sendFrame(1'b0, 6'd0, 11'd1999, 1'b1);
      chk("wrap_old_width", pulse_us, REST_US);
      tick(PER_CYC - 1);
      chk("wrap_still_old", pulse_us, REST_US);
      tick(1);
      chk("wrap_new_width", pulse_us, 1999);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
